// File: rtl/rcb_array_if.sv
// Host/feed bus bundle for rcb_array: shared read port, host write
// handshake and status outputs. The slave modport is the RAM array side.
interface rcb_array_if #(
  parameter int NUM_CH    = 4,
  parameter int RAM_WIDTH = 128,
  parameter int ADDR_W    = 8
);
  logic [ADDR_W-1:0]           t2t_rd_addr;
  logic                        sef_read;
  logic                        slf_inmsg;
  logic [NUM_CH*RAM_WIDTH-1:0] rcb_data;
  logic                        rcb_data_vld;
  logic [ADDR_W-1:0]           hpb_wr_addr;
  logic [RAM_WIDTH-1:0]        hpb_wr_data;
  logic [NUM_CH-1:0]           hpb_wr_en;
  logic                        hpb_wr_req;
  logic                        rcb_wr_done;
  logic                        rcb_wr_busy;
  logic [15:0]                 rcb_wr_stall_cnt;

  modport master (
    output t2t_rd_addr, sef_read, slf_inmsg,
    output hpb_wr_addr, hpb_wr_data, hpb_wr_en, hpb_wr_req,
    input  rcb_data, rcb_data_vld, rcb_wr_done, rcb_wr_busy, rcb_wr_stall_cnt
  );

  modport slave (
    input  t2t_rd_addr, sef_read, slf_inmsg,
    input  hpb_wr_addr, hpb_wr_data, hpb_wr_en, hpb_wr_req,
    output rcb_data, rcb_data_vld, rcb_wr_done, rcb_wr_busy, rcb_wr_stall_cnt
  );
endinterface

// File: rtl/rcb_array.sv
// rcb_array: NUM_CH parallel RAM channels sharing one read address, with a
// host write port arbitrated so that a RAM write never shares a cycle with a
// RAM read (and, with HOST_ARB=0, never lands inside a feed message).
module rcb_array #(
  parameter int NUM_CH    = 4,
  parameter int RAM_WIDTH = 128,
  parameter int ADDR_W    = 8,
  parameter int REG_ADDR  = 1,
  parameter int HOST_ARB  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  rcb_array_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [RAM_WIDTH-1:0] mem_q [NUM_CH][DEPTH];

  state_e                      state_q, state_d;
  logic [15:0]                 stall_q, stall_d;
  logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
  logic [RAM_WIDTH-1:0]        wr_data_q, wr_data_d;
  logic [NUM_CH-1:0]           wr_en_q, wr_en_d;
  logic                        ram_we;
  logic                        blocked;

  logic [ADDR_W-1:0]           rd_addr_p0_q, rd_addr_p0_d;
  logic                        vld_p0_q, vld_p0_d;
  logic                        ram_rd_en;
  logic [ADDR_W-1:0]           ram_rd_addr;
  logic [NUM_CH*RAM_WIDTH-1:0] rd_word;
  logic [NUM_CH*RAM_WIDTH-1:0] rcb_data_q, rcb_data_d;
  logic                        rcb_data_vld_q, rcb_data_vld_d;

  // Read address stage and RAM access select; p0 only exists when REG_ADDR=1.
  always_comb begin
    vld_p0_d     = (REG_ADDR != 0) && bus.sef_read;
    rd_addr_p0_d = bus.sef_read ? bus.t2t_rd_addr : rd_addr_p0_q;
    if (REG_ADDR != 0) begin
      ram_rd_en   = vld_p0_q;
      ram_rd_addr = rd_addr_p0_q;
    end else begin
      ram_rd_en   = bus.sef_read;
      ram_rd_addr = bus.t2t_rd_addr;
    end
  end

  // Gather one word per channel at the shared read address.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rd_word[k*RAM_WIDTH +: RAM_WIDTH] = mem_q[k][ram_rd_addr];
    end
  end

  // Output register holds the last read result between valid pulses.
  always_comb begin
    rcb_data_d     = ram_rd_en ? rd_word : rcb_data_q;
    rcb_data_vld_d = ram_rd_en;
  end

  // A write is held off by any read in flight and, in message-atomic mode,
  // for the whole feed message.
  always_comb begin
    blocked = bus.sef_read || vld_p0_q || ((HOST_ARB == 0) && bus.slf_inmsg);
  end

  // Write handshake FSM: capture in IDLE, wait for a free cycle, ack in DONE.
  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = wr_en_q;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.hpb_wr_req) begin
          wr_addr_d = bus.hpb_wr_addr;
          wr_data_d = bus.hpb_wr_data;
          wr_en_d   = bus.hpb_wr_en;
          stall_d   = 16'd0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (!bus.hpb_wr_req) begin
          state_d = IDLE;
        end else if (blocked) begin
          stall_d = sat_inc(stall_q);
        end else begin
          ram_we  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.hpb_wr_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      stall_q        <= 16'd0;
      vld_p0_q       <= 1'b0;
      rcb_data_q     <= '0;
      rcb_data_vld_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_q        <= stall_d;
      vld_p0_q       <= vld_p0_d;
      rcb_data_q     <= rcb_data_d;
      rcb_data_vld_q <= rcb_data_vld_d;
    end
  end

  // Captured write request and registered read address carry no reset.
  always_ff @(posedge clk) begin
    wr_addr_q    <= wr_addr_d;
    wr_data_q    <= wr_data_d;
    wr_en_q      <= wr_en_d;
    rd_addr_p0_q <= rd_addr_p0_d;
  end

  // RAM write: every channel whose mask bit is set takes the captured word.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en_q[k]) begin
          mem_q[k][wr_addr_q] <= wr_data_q;
        end
      end
    end
  end

  assign bus.rcb_data         = rcb_data_q;
  assign bus.rcb_data_vld     = rcb_data_vld_q;
  assign bus.rcb_wr_done      = (state_q == DONE);
  assign bus.rcb_wr_busy      = (state_q != IDLE);
  assign bus.rcb_wr_stall_cnt = stall_q;

endmodule

// File: doc/rcb_array.md
RCB_ARRAY -- requirements
Module: rcb_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of RAM channels (symbol/price/volume/order), range 1-8.
REQ-002 SHALL have parameter RAM_WIDTH, default 128, data width in bits of every channel.
REQ-003 SHALL have parameter ADDR_W, default 8, address width; depth is 2^ADDR_W per channel.
REQ-004 SHALL have parameter REG_ADDR, default 1; 1 registers the read address, adding one cycle of read latency.
REQ-005 SHALL have parameter HOST_ARB, default 0; 0 blocks host writes while slf_inmsg=1 (message-atomic), 1 blocks host writes only on read cycles.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port t2t_rd_addr, input, ADDR_W, shared read address for all channels.
REQ-009 SHALL have port sef_read, input, 1, read strobe.
REQ-010 SHALL have port slf_inmsg, input, 1, high for the duration of a feed message.
REQ-011 SHALL have port rcb_data, output, NUM_CH*RAM_WIDTH, read data; channel k occupies bits [k*RAM_WIDTH +: RAM_WIDTH].
REQ-012 SHALL have port rcb_data_vld, output, 1, one-cycle pulse qualifying rcb_data.
REQ-013 SHALL have ports hpb_wr_addr (input, ADDR_W), hpb_wr_data (input, RAM_WIDTH) and hpb_wr_en (input, NUM_CH), the last being a per-channel write mask (multiple bits = broadcast).
REQ-014 SHALL have port hpb_wr_req, input, 1, level write request, four-phase handshake.
REQ-015 SHALL have port rcb_wr_done, output, 1, write-completion acknowledge.
REQ-016 SHALL have port rcb_wr_busy, output, 1, high while a captured write is pending or unacknowledged.
REQ-017 SHALL have port rcb_wr_stall_cnt, output, 16, count of blocked cycles for the current write.

Function
REQ-018 Read: sef_read=1 at cycle N SHALL give rcb_data for t2t_rd_addr (sampled at N) and rcb_data_vld=1 at N+1 (REG_ADDR=0) or N+2 (REG_ADDR=1).
REQ-019 rcb_data SHALL hold its last value when rcb_data_vld=0; back-to-back reads SHALL sustain one result per cycle.
REQ-020 Write FSM states SHALL be IDLE, WAIT, DONE.
REQ-021 IDLE: hpb_wr_req=1 SHALL capture addr, data and mask, clear rcb_wr_stall_cnt, and enter WAIT next cycle.
REQ-022 Block condition: sef_read=1, or a read in the REG_ADDR pipeline stage, or (HOST_ARB=0 and slf_inmsg=1).
REQ-023 WAIT, not blocked: SHALL write captured data to every channel with a set mask bit in that same cycle, then enter DONE.
REQ-024 WAIT, blocked: SHALL stay in WAIT and increment rcb_wr_stall_cnt, saturating at 16'hFFFF.
REQ-025 WAIT with hpb_wr_req=0 SHALL abort to IDLE with no RAM write and no rcb_wr_done, taking priority over REQ-023.
REQ-026 DONE: rcb_wr_done SHALL be 1; on hpb_wr_req=0, return to IDLE with rcb_wr_done=0 next cycle.
REQ-027 rcb_wr_busy SHALL be 1 in WAIT and DONE, 0 in IDLE.
REQ-028 An all-zero mask SHALL complete the handshake without modifying any RAM.
REQ-029 No read and RAM write SHALL ever coincide on the same cycle, so read data is never mixed old/new.
REQ-030 HOST_ARB=0: no write SHALL occur between the rising and falling edges of slf_inmsg; continuous blocking waits indefinitely (no timeout).

Reset
REQ-031 reset_n=0 SHALL asynchronously force the FSM to IDLE and rcb_data=0, rcb_data_vld=0, rcb_wr_done=0, rcb_wr_busy=0, rcb_wr_stall_cnt=0.
REQ-032 Reset mid-write SHALL discard the pending write; RAM contents are not reset and are undefined until written.

Verification
REQ-033 Write mask 4'b0010, addr 8'h05, data 128'hA5; then read 8'h05 with REG_ADDR=1 -> done asserted; rcb_data channel1=128'hA5 exactly 2 cycles after sef_read.
REQ-034 HOST_ARB=0, slf_inmsg held high for 10 cycles during a write request -> no write until slf_inmsg falls; rcb_wr_stall_cnt=10.
REQ-035 HOST_ARB=1, sef_read pulsed every other cycle with REG_ADDR=0 -> write lands only in a non-read cycle; reads return pre-write data until then.
REQ-036 Broadcast mask 4'b1111 to addr 8'hFF -> all four channels read back identical data.
REQ-037 hpb_wr_req dropped while in WAIT -> no RAM change, rcb_wr_done never pulses, busy falls next cycle.
REQ-038 reset_n asserted while in DONE -> all outputs 0 immediately; a new request after reset completes normally.
